night_rider_scanner: RTL and testbench
======================================

Name: night_rider_scanner

Overview:
Parametrised LED scanner. One lit "head" LED steps across an N-wide bar. The step rate is runtime-programmable, and the block supports bounce or wrap-around modes. A PWM-dimmed trail of up to TAIL previous positions follows the head. It drives a front-panel LED bar directly from the system clock and needs no external divider.

Parameters:
N, 8, LED count; legal range 2..256
DIV_W, 16, width of step-period divider input
TAIL, 3, trail length in positions; legal range 0..7 (0 = no trail)
PWM_W, 4, PWM counter width; trail brightness resolution is 2^PWM_W

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  1 = scanning; 0 = head frozen, prescaler cleared
mode  in  2  00 bounce, 01 wrap-up, 10 wrap-down, 11 hold
step_div  in  DIV_W  head moves once every step_div+1 clocks
led_out  out  N  LED drive, bit i = LED i
head_pos  out  $clog2(N)  current head index
step  out  1  one-cycle pulse in the cycle the head moves

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk. All state is reset asynchronously; all updates happen on posedge clk.
- Reset values:
  - head_pos=0, dir=up, prescaler=0, pwm_cnt=0, all trail entries invalid, step=0.
  - led_out=1 (bit 0 only), valid in the same cycle reset is asserted.
- Prescaler (tick_gen):
  - With en=1, cnt increments each clock.
  - When cnt>=step_div: tick=1 and cnt<=0. The >= covers step_div being lowered mid-count, so no stall occurs.
  - step_div=0 gives a tick every clock.
  - en=0 forces cnt<=0 and tick=0.
- step equals tick registered together with the head update, so step is high in the first cycle head_pos shows the new value.
- Head update on tick (mode sampled at the tick):
  - bounce: moving up, pos+1; at pos=N-1, go to N-2 and set dir=down. Moving down, pos-1; at pos=0, go to 1 and set dir=up. End LEDs are lit for exactly one step. Sequence for N=8: 0,1,...,7,6,...,1,0,1,...
  - wrap-up: N-1 -> 0, otherwise pos+1; dir forced up.
  - wrap-down: 0 -> N-1, otherwise pos-1; dir forced down.
  - hold: pos unchanged, trail unchanged, step still pulses.
  - Switching into bounce continues from the current pos and dir.
  - N=2 bounce: 0,1,0,1.
- Trail:
  - Shift register of TAIL entries {valid, pos}.
  - On every moving tick (not hold), entry0<=old head, entry k<=entry k-1, and the valid bits shift the same way.
  - Entries become valid only as real positions shift in.
- PWM:
  - pwm_cnt is PWM_W bits, free-running every clock; it is reset-only and ignores en.
  - Trail entry k (k=1..TAIL, entry0 is k=1) is lit when valid and pwm_cnt < (2^PWM_W >> k). Duty is 50%, 25%, 12.5%, and so on.
  - If 2^PWM_W >> k = 0, that entry is never lit.
- led_out combining:
  - led_out = onehot(head_pos) OR all lit trail bits.
  - The head is always fully on, even where it overlaps a trail entry.
  - Duplicate trail positions (bounce turnaround) are ORed, so the brightest duty wins.
  - led_out is registered: it reflects the head_pos and pwm_cnt of the current cycle, with 1 cycle of latency from the state registers. It must be glitch-free.
- en falling mid-count: head, trail and dir hold. On en rising, the first tick comes step_div+1 clocks later.
- Reset asserted mid-scan returns to the reset values immediately. The first tick after release comes step_div+1 clocks after the first en=1 edge.
- Elaboration error if N<2 or TAIL>7.

Decomposition:
- Package night_rider_pkg:
  - mode localparams MODE_BOUNCE=2'b00, MODE_WRAP_UP=2'b01, MODE_WRAP_DN=2'b10, MODE_HOLD=2'b11.
  - DIR_UP=1'b1, DIR_DN=1'b0.
  - function onehot(pos, N).
- Sub-module night_rider_tick_gen #(DIV_W): ports clk, rst_n, en, step_div -> tick.
- Head/trail state machine, PWM and output combining stay in night_rider_scanner.

Test Plan:
- Reset with N=8, TAIL=0, step_div=0, en=1, bounce -> head_pos sequence 0,1,...,7,6,...,1,0,1 on consecutive clocks; step high every clock; led_out one-hot matching head_pos.
- step_div=3, wrap-up -> head moves every 4 clocks, 7 -> 0 wrap observed; switch to wrap-down at pos=2 -> 1,0,7,6.
- TAIL=3, PWM_W=4, step_div=99, bounce after head reaches 5 (trail 4,3,2) -> over 16 clocks LED4 on 8, LED3 on 4, LED2 on 2 cycles, LED5 on 16; LEDs 0,1,6,7 never on.
- Turnaround: head at 7 then 6 -> trail entry0=7, entry1=6 masked by head; LED6 constantly on, LED7 at 50% duty.
- en=0 for 20 clocks mid-count with step_div=9 -> no step pulse, head stable; en=1 -> first step exactly 10 clocks later. mode=hold -> step pulses, led pattern frozen.
- rst_n asserted asynchronously between clock edges mid-scan (head=5, trail valid) -> led_out=8'h01 and head_pos=0 before the next edge; all trail LEDs dark after release.

Source files
------------

// File: rtl/night_rider_pkg.sv
// Shared constants and helpers for the night rider LED scanner.
package night_rider_pkg;

  localparam logic [1:0] MODE_BOUNCE  = 2'b00;
  localparam logic [1:0] MODE_WRAP_UP = 2'b01;
  localparam logic [1:0] MODE_WRAP_DN = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Widest bar the scanner supports; onehot() returns this width.
  localparam int MAX_N = 256;

  // One-hot vector with bit 'pos' set; all-zero when pos is outside the bar.
  function automatic logic [MAX_N-1:0] onehot(input int unsigned pos, input int unsigned n);
    logic [MAX_N-1:0] v;
    v = '0;
    if (pos < n) v[pos[7:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/night_rider_if.sv
// Control inputs and LED-bar outputs of the scanner, bundled as one port.
// Handshake: there is none -- en/mode/step_div are level controls sampled on
// every rising clk edge; led_out/head_pos/step are registered and valid every
// cycle, with step a single-cycle pulse marking the cycle the head moved.
interface night_rider_if #(
  parameter int N     = 8,
  parameter int DIV_W = 16
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic             en;
  logic [1:0]       mode;
  logic [DIV_W-1:0] step_div;
  logic [N-1:0]     led_out;
  logic [PW-1:0]    head_pos;
  logic             step;
  logic             dbg_dir;   // current sweep direction (1 = up)

  modport master (
    output en, mode, step_div,
    input  led_out, head_pos, step, dbg_dir
  );

  modport slave (
    input  en, mode, step_div,
    output led_out, head_pos, step, dbg_dir
  );
endinterface

// File: rtl/night_rider_tick_gen.sv
// Step prescaler: one tick every step_div+1 enabled clocks.
module night_rider_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] step_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Count enabled clocks; >= lets a lowered step_div fire at once instead of stalling.
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q >= step_div) begin
      tick  = 1'b1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/night_rider_scanner.sv
// LED bar scanner: stepping head with bounce/wrap modes and a PWM-dimmed trail.
module night_rider_scanner
  import night_rider_pkg::*;
#(
  parameter int N     = 8,
  parameter int DIV_W = 16,
  parameter int TAIL  = 3,
  parameter int PWM_W = 4
) (
  input logic          clk,
  input logic          rst_n,
  night_rider_if.slave bus
);

  localparam int PW = $clog2(N);
  localparam int TS = (TAIL > 0) ? TAIL : 1;
  localparam logic [PW-1:0] LAST = PW'(N - 1);

  if (N < 2 || N > MAX_N || TAIL < 0 || TAIL > 7) begin : g_bad_param
    $error("night_rider_scanner: N must be 2..256 and TAIL 0..7");
  end

  logic tick;

  night_rider_tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (bus.en),
    .step_div (bus.step_div),
    .tick     (tick)
  );

  logic [PW-1:0]    head_q, head_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic [PW-1:0]    trail_pos_q [TS];
  logic [PW-1:0]    trail_pos_d [TS];
  logic [TS-1:0]    trail_vld_q, trail_vld_d;
  logic [PWM_W-1:0] pwm_q, pwm_d;
  logic [N-1:0]     led_q, led_d;
  logic             moving;

  // Next head/direction/trail; mode is sampled only in tick cycles.
  always_comb begin
    head_d      = head_q;
    dir_d       = dir_q;
    trail_pos_d = trail_pos_q;
    trail_vld_d = trail_vld_q;
    step_d      = tick;
    moving      = 1'b0;
    if (tick) begin
      case (bus.mode)
        MODE_BOUNCE: begin
          moving = 1'b1;
          if (dir_q == DIR_UP) begin
            if (head_q == LAST) begin
              head_d = head_q - PW'(1);
              dir_d  = DIR_DN;
            end else begin
              head_d = head_q + PW'(1);
            end
          end else begin
            if (head_q == '0) begin
              head_d = PW'(1);
              dir_d  = DIR_UP;
            end else begin
              head_d = head_q - PW'(1);
            end
          end
        end
        MODE_WRAP_UP: begin
          moving = 1'b1;
          dir_d  = DIR_UP;
          head_d = (head_q == LAST) ? '0 : head_q + PW'(1);
        end
        MODE_WRAP_DN: begin
          moving = 1'b1;
          dir_d  = DIR_DN;
          head_d = (head_q == '0) ? LAST : head_q - PW'(1);
        end
        default: moving = 1'b0;
      endcase
    end
    if (moving && (TAIL > 0)) begin
      for (int k = TS - 1; k > 0; k--) begin
        trail_pos_d[k] = trail_pos_q[k-1];
        trail_vld_d[k] = trail_vld_q[k-1];
      end
      trail_pos_d[0] = head_q;
      trail_vld_d[0] = 1'b1;
    end
  end

  // LED image built from next-state values so the registered bar lines up with head_pos.
  always_comb begin
    pwm_d = pwm_q + PWM_W'(1);
    led_d = N'(onehot(32'(head_d), N));
    for (int k = 0; k < TAIL; k++) begin
      if (trail_vld_d[k] && (int'(pwm_d) < ((1 << PWM_W) >> (k + 1))))
        led_d[trail_pos_d[k]] = 1'b1;
    end
  end

  // State, PWM counter and output registers; led_out shows LED 0 while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      dir_q       <= DIR_UP;
      step_q      <= 1'b0;
      pwm_q       <= '0;
      led_q       <= N'(1);
      trail_vld_q <= '0;
      for (int k = 0; k < TS; k++) trail_pos_q[k] <= '0;
    end else begin
      head_q      <= head_d;
      dir_q       <= dir_d;
      step_q      <= step_d;
      pwm_q       <= pwm_d;
      led_q       <= led_d;
      trail_vld_q <= trail_vld_d;
      trail_pos_q <= trail_pos_d;
    end
  end

  assign bus.led_out  = led_q;
  assign bus.head_pos = head_q;
  assign bus.step     = step_q;
  assign bus.dbg_dir  = dir_q;

endmodule

// File: tb/tb_night_rider_scanner.sv
// Self-checking bench for night_rider_scanner (N=8, TAIL=3, PWM_W=4).
module tb_night_rider_scanner;
  import night_rider_pkg::*;

  localparam int N     = 8;
  localparam int DIV_W = 16;
  localparam int TAIL  = 3;
  localparam int PWM_W = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  night_rider_if #(.N(N), .DIV_W(DIV_W)) bus ();

  night_rider_scanner #(.N(N), .DIV_W(DIV_W), .TAIL(TAIL), .PWM_W(PWM_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_pos  = 0;
  bit m_up   = 1'b1;
  int m_cnt  = 0;
  int m_pwm  = 0;
  bit m_step = 1'b0;
  bit m_tick;
  int m_hist[$];   // previous head positions, most recent first

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos = 0; m_up = 1'b1; m_cnt = 0; m_pwm = 0; m_step = 1'b0;
      m_hist.delete();
    end else begin
      m_pwm  = (m_pwm + 1) % (1 << PWM_W);
      m_tick = 1'b0;
      if (!bus.en) m_cnt = 0;
      else if (m_cnt >= int'(bus.step_div)) begin m_tick = 1'b1; m_cnt = 0; end
      else m_cnt++;
      m_step = m_tick;
      if (m_tick && bus.mode != MODE_HOLD) begin
        m_hist.push_front(m_pos);
        if (m_hist.size() > TAIL) void'(m_hist.pop_back());
        case (bus.mode)
          MODE_BOUNCE:
            if (m_up) begin
              if (m_pos == N - 1) begin m_pos = N - 2; m_up = 1'b0; end
              else m_pos++;
            end else begin
              if (m_pos == 0) begin m_pos = 1; m_up = 1'b1; end
              else m_pos--;
            end
          MODE_WRAP_UP: begin m_up = 1'b1; m_pos = (m_pos + 1) % N; end
          default:      begin m_up = 1'b0; m_pos = (m_pos + N - 1) % N; end
        endcase
      end
    end
  end

  function automatic logic [N-1:0] exp_led();
    logic [N-1:0] v;
    v = '0;
    for (int k = 1; k <= TAIL; k++)
      if (m_hist.size() >= k && m_pwm < ((1 << PWM_W) >> k)) v[m_hist[k-1]] = 1'b1;
    v[m_pos] = 1'b1;
    return v;
  endfunction

  // ---------------- scoreboard: compare every cycle ----------------
  always @(negedge clk) begin
    check("head_pos", 64'(bus.head_pos), 64'(m_pos));
    check("step",     64'(bus.step),     64'(m_step));
    check("led_out",  64'(bus.led_out),  64'(exp_led()));
  end

  // ---------------- driver tasks ----------------
  int led_cnt[N];

  task automatic do_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic count16();
    for (int j = 0; j < N; j++) led_cnt[j] = 0;
    repeat (16) begin
      @(negedge clk);
      for (int j = 0; j < N; j++) led_cnt[j] += int'(bus.led_out[j]);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int seq1[16] = '{0,1,2,3,4,5,6,7,6,5,4,3,2,1,0,1};
    int duty5[N] = '{0,0,2,4,8,16,0,0};
    int turn[N]  = '{0,0,0,0,0,2,16,8};
    int wrapdn[4] = '{1,0,7,6};
    int prev, nstep, nsame, first, idx;
    bit found, wrapped;

    bus.en = 1'b0; bus.mode = MODE_BOUNCE; bus.step_div = '0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_led",  64'(bus.led_out),  64'h01);
    check("reset_head", 64'(bus.head_pos), 64'd0);
    check("reset_step", 64'(bus.step),     64'd0);

    // Bounce at full rate: head sweeps every clock.
    bus.en = 1'b1; bus.mode = MODE_BOUNCE; bus.step_div = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("bounce_seq", 64'(bus.head_pos), 64'(seq1[i]));
    end

    // Trail duty at head=5 (trail 4,3,2), then the turnaround at 7 -> 6.
    bus.step_div = '0;
    do_reset();
    repeat (5) @(posedge clk);
    #2 bus.step_div = 16'd99;
    count16();
    for (int j = 0; j < N; j++) check("trail_duty", 64'(led_cnt[j]), 64'(duty5[j]));
    bus.step_div = '0;
    found = 1'b0; prev = -1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (prev == 7 && int'(bus.head_pos) == 6) found = 1'b1;
      prev = int'(bus.head_pos);
    end
    bus.en = 1'b0;
    check("turn_found", 64'(found), 64'd1);
    count16();
    for (int j = 0; j < N; j++) check("turn_duty", 64'(led_cnt[j]), 64'(turn[j]));

    // Wrap-up with step_div=3, then wrap-down from head 2.
    bus.en = 1'b1; bus.mode = MODE_WRAP_UP; bus.step_div = 16'd3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.step) found = 1'b1;
    end
    check("wrap_first_step", 64'(found), 64'd1);
    nstep = 0; wrapped = 1'b0; prev = int'(bus.head_pos);
    repeat (40) begin
      @(negedge clk);
      if (bus.step) nstep++;
      if (prev == 7 && int'(bus.head_pos) == 0) wrapped = 1'b1;
      prev = int'(bus.head_pos);
    end
    check("wrap_step_count", 64'(nstep), 64'd10);
    check("wrap_7_to_0", 64'(wrapped), 64'd1);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (int'(bus.head_pos) == 2) found = 1'b1;
    end
    check("wrap_reach_2", 64'(found), 64'd1);
    bus.mode = MODE_WRAP_DN;
    idx = 0;
    for (int i = 0; i < 40 && idx < 4; i++) begin
      @(negedge clk);
      if (bus.step) begin
        check("wrapdn_seq", 64'(bus.head_pos), 64'(wrapdn[idx]));
        idx++;
      end
    end
    check("wrapdn_steps", 64'(idx), 64'd4);

    // en low mid-count: nothing moves; first step comes step_div+1 clocks after en rises.
    bus.en = 1'b1; bus.mode = MODE_BOUNCE; bus.step_div = 16'd9;
    do_reset();
    repeat (5) @(negedge clk);
    bus.en = 1'b0;
    nstep = 0; nsame = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.step) nstep++;
      if (bus.head_pos == 0) nsame++;
    end
    check("en_low_steps", 64'(nstep), 64'd0);
    check("en_low_head",  64'(nsame), 64'd20);
    bus.en = 1'b1;
    first = 0;
    for (int i = 1; i <= 15 && first == 0; i++) begin
      @(negedge clk);
      if (bus.step) first = i;
    end
    check("en_rise_latency", 64'(first), 64'd10);

    // Hold: step keeps pulsing, head stays put.
    bus.mode = MODE_HOLD; bus.step_div = '0;
    nstep = 0; nsame = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.step) nstep++;
      if (bus.head_pos == 1) nsame++;
    end
    check("hold_steps", 64'(nstep), 64'd8);
    check("hold_head",  64'(nsame), 64'd8);

    // Asynchronous reset between edges with head=5 and a valid trail.
    bus.mode = MODE_BOUNCE; bus.step_div = '0; bus.en = 1'b1;
    do_reset();
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_led",  64'(bus.led_out),  64'h01);
    check("async_head", 64'(bus.head_pos), 64'd0);
    check("async_step", 64'(bus.step),     64'd0);
    bus.en = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    count16();
    check("post_reset_led0",  64'(led_cnt[0]), 64'd16);
    nsame = 0;
    for (int j = 1; j < N; j++) nsame += led_cnt[j];
    check("post_reset_trail", 64'(nsame), 64'd0);

    // Randomised run checked by the model.
    bus.en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 19) == 0) bus.en = 1'b0;
      else if ($urandom_range(0, 3) == 0) bus.en = 1'b1;
      if ($urandom_range(0, 31) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) bus.step_div = DIV_W'($urandom_range(0, 5));
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
